// File: rtl/pulse_channel1.sv
// Square-wave tone channel: duty sequencer, length counter, volume envelope and
// frequency sweep, producing a registered 4-bit DAC sample.
module pulse_channel1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk256,
  input  logic        clk128,
  input  logic        clk64,
  input  logic [2:0]  swpPd,
  input  logic        negate,
  input  logic [2:0]  shift,
  input  logic [10:0] freq,
  input  logic [5:0]  lenLoad,
  input  logic [1:0]  duty,
  input  logic [3:0]  startVol,
  input  logic [2:0]  period,
  input  logic        lenEnable,
  input  logic        trigger,
  input  logic        envAdd,
  output logic [3:0]  out
);

  localparam int unsigned FREQ_W = 11;
  localparam int unsigned CALC_W = FREQ_W + 1;
  localparam int unsigned TMR_W  = 14;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned VOL_W  = 4;
  localparam int unsigned SWT_W  = 4;
  localparam logic [CALC_W-1:0] FREQ_MAX = CALC_W'(2047);

  logic              trig_q,      trig_d;
  logic              enabled_q,   enabled_d;
  logic [LEN_W-1:0]  length_q,    length_d;
  logic [VOL_W-1:0]  volume_q,    volume_d;
  logic [2:0]        env_tmr_q,   env_tmr_d;
  logic [2:0]        duty_pos_q,  duty_pos_d;
  logic [TMR_W-1:0]  freq_tmr_q,  freq_tmr_d;
  logic [FREQ_W-1:0] shadow_q,    shadow_d;
  logic [SWT_W-1:0]  sweep_tmr_q, sweep_tmr_d;
  logic              sweep_en_q,  sweep_en_d;
  logic [VOL_W-1:0]  out_q,       out_d;

  logic [FREQ_W-1:0] cur_freq;
  logic [CALC_W-1:0] sw_new;
  logic [7:0]        pattern;
  logic [SWT_W-1:0]  sweep_reload;

  // shadow +/- (shadow >> shift); the shifted term never exceeds shadow, so no underflow
  function automatic logic [CALC_W-1:0] sweep_calc(input logic [FREQ_W-1:0] s,
                                                    input logic [2:0] sh,
                                                    input logic neg);
    logic [CALC_W-1:0] base;
    logic [CALC_W-1:0] delta;
    base  = {1'b0, s};
    delta = {1'b0, s >> sh};
    return neg ? (base - delta) : (base + delta);
  endfunction

  // (2048 - f) * 4
  function automatic logic [TMR_W-1:0] freq_reload(input logic [FREQ_W-1:0] f);
    logic [CALC_W-1:0] diff;
    diff = CALC_W'(2048) - {1'b0, f};
    return {diff, 2'b00};
  endfunction

  always_comb begin
    unique case (duty)
      2'd0:    pattern = 8'b0000_0001;
      2'd1:    pattern = 8'b1000_0001;
      2'd2:    pattern = 8'b1000_0111;
      default: pattern = 8'b0111_1110;
    endcase
  end

  assign cur_freq     = sweep_en_q ? shadow_q : freq;
  assign sweep_reload = (swpPd == 3'd0) ? SWT_W'(8) : {1'b0, swpPd};

  always_comb begin
    trig_d      = trigger;
    enabled_d   = enabled_q;
    length_d    = length_q;
    volume_d    = volume_q;
    env_tmr_d   = env_tmr_q;
    duty_pos_d  = duty_pos_q;
    freq_tmr_d  = freq_tmr_q;
    shadow_d    = shadow_q;
    sweep_tmr_d = sweep_tmr_q;
    sweep_en_d  = sweep_en_q;
    sw_new      = '0;

    // Frequency timer free-runs even while the channel is disabled
    if (freq_tmr_q <= TMR_W'(1)) begin
      freq_tmr_d = freq_reload(cur_freq);
      duty_pos_d = duty_pos_q + 3'd1;
    end else begin
      freq_tmr_d = freq_tmr_q - TMR_W'(1);
    end

    if (trigger && !trig_q) begin
      enabled_d   = 1'b1;
      length_d    = LEN_W'(64) - {1'b0, lenLoad};
      volume_d    = startVol;
      env_tmr_d   = period;
      duty_pos_d  = 3'd0;
      freq_tmr_d  = freq_reload(freq);
      shadow_d    = freq;
      sweep_tmr_d = sweep_reload;
      sweep_en_d  = (swpPd != 3'd0) || (shift != 3'd0);
      if ((shift != 3'd0) && (sweep_calc(freq, shift, negate) > FREQ_MAX)) begin
        enabled_d = 1'b0;
      end
    end else begin
      if (clk256 && lenEnable && (length_q != '0)) begin
        length_d = length_q - LEN_W'(1);
        if (length_q == LEN_W'(1)) enabled_d = 1'b0;
      end

      if (clk64 && (period != 3'd0)) begin
        if (env_tmr_q <= 3'd1) begin
          env_tmr_d = period;
          if (envAdd && (volume_q != VOL_W'(15))) begin
            volume_d = volume_q + VOL_W'(1);
          end else if (!envAdd && (volume_q != '0)) begin
            volume_d = volume_q - VOL_W'(1);
          end
        end else begin
          env_tmr_d = env_tmr_q - 3'd1;
        end
      end

      if (clk128) begin
        if (sweep_tmr_q <= SWT_W'(1)) begin
          sweep_tmr_d = sweep_reload;
          if (sweep_en_q && (swpPd != 3'd0)) begin
            sw_new = sweep_calc(shadow_q, shift, negate);
            if (sw_new > FREQ_MAX) begin
              enabled_d = 1'b0;
            end else if (shift != 3'd0) begin
              shadow_d = sw_new[FREQ_W-1:0];
              if (sweep_calc(sw_new[FREQ_W-1:0], shift, negate) > FREQ_MAX) enabled_d = 1'b0;
            end
          end
        end else begin
          sweep_tmr_d = sweep_tmr_q - SWT_W'(1);
        end
      end
    end

    // DAC powered off: no volume and no upward envelope
    if ((startVol == '0) && !envAdd) enabled_d = 1'b0;

    out_d = (enabled_q && pattern[3'd7 - duty_pos_q]) ? volume_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      enabled_q   <= 1'b0;
      length_q    <= '0;
      volume_q    <= '0;
      env_tmr_q   <= '0;
      duty_pos_q  <= '0;
      freq_tmr_q  <= '0;
      shadow_q    <= '0;
      sweep_tmr_q <= '0;
      sweep_en_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      trig_q      <= trig_d;
      enabled_q   <= enabled_d;
      length_q    <= length_d;
      volume_q    <= volume_d;
      env_tmr_q   <= env_tmr_d;
      duty_pos_q  <= duty_pos_d;
      freq_tmr_q  <= freq_tmr_d;
      shadow_q    <= shadow_d;
      sweep_tmr_q <= sweep_tmr_d;
      sweep_en_q  <= sweep_en_d;
      out_q       <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pulse_channel1.sv
// Scoreboard bench for pulse_channel1: stimulus queues expected samples keyed by
// clock count; a negedge monitor pops and compares them against out.
module tb_pulse_channel1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  val;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk256, clk128, clk64;
  logic [2:0]  swpPd, shift, period;
  logic        negate, lenEnable, trigger, envAdd;
  logic [10:0] freq;
  logic [5:0]  lenLoad;
  logic [1:0]  duty;
  logic [3:0]  startVol;
  logic [3:0]  out;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  pulse_channel1 dut (
    .clk(clk), .rst_n(rst_n), .clk256(clk256), .clk128(clk128), .clk64(clk64),
    .swpPd(swpPd), .negate(negate), .shift(shift), .freq(freq), .lenLoad(lenLoad),
    .duty(duty), .startVol(startVol), .period(period), .lenEnable(lenEnable),
    .trigger(trigger), .envAdd(envAdd), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expected sample due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: sample for cycle %0d not taken (now %0d)", e.tag, e.cyc, cyc);
      end else if (out !== e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: out=%0d expected %0d", e.tag, cyc, out, e.val);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_at(input int unsigned c, input logic [3:0] v, input string t);
    sb.push_back('{cyc: c, val: v, tag: t});
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic defaults();
    swpPd = 0; negate = 0; shift = 0; freq = 0; lenLoad = 0; duty = 0;
    startVol = 0; period = 0; lenEnable = 0; envAdd = 0;
    clk256 = 0; clk128 = 0; clk64 = 0;
  endtask

  // Strobe is high for the posedge that brings cyc to 'at'
  task automatic pulse(input int unsigned at, input int which);
    goto(at - 1);
    if (which == 256) clk256 = 1'b1;
    else if (which == 128) clk128 = 1'b1;
    else clk64 = 1'b1;
    @(negedge clk);
    clk256 = 1'b0; clk128 = 1'b0; clk64 = 1'b0;
  endtask

  // Returns the cycle whose posedge sees the rising trigger edge
  task automatic fire(output int unsigned p);
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    p = cyc + 1;
  endtask

  initial begin
    int unsigned p;
    int unsigned q;
    rst_n = 1'b0; trigger = 1'b0;
    defaults();
    expect_at(1, 4'd0, "reset");
    expect_at(2, 4'd0, "reset");
    expect_at(5, 4'd0, "idle_after_reset");
    @(negedge clk);
    goto(3);
    rst_n = 1'b1;
    goto(6);

    // Duty 2 tone, 1024 clk per step
    freq = 11'd1792; duty = 2'd2; startVol = 4'd15;
    fire(p);
    expect_at(p + 1,    4'd15, "tone_pos0_start");
    expect_at(p + 1024, 4'd15, "tone_pos0_end");
    expect_at(p + 1025, 4'd0,  "tone_pos1");
    expect_at(p + 5120, 4'd0,  "tone_pos4_end");
    expect_at(p + 5121, 4'd15, "tone_pos5");
    expect_at(p + 8192, 4'd15, "tone_pos7_end");
    expect_at(p + 9216, 4'd15, "tone_wrap_pos0");
    expect_at(p + 9217, 4'd0,  "tone_wrap_pos1");
    goto(p + 9220);

    // Length expiry after two clk256 strobes
    defaults();
    freq = 11'd2047; duty = 2'd3; startVol = 4'd15; lenLoad = 6'd62; lenEnable = 1'b1;
    fire(p);
    expect_at(p + 6,  4'd15, "len_active");
    expect_at(p + 18, 4'd15, "len_one_left");
    expect_at(p + 21, 4'd0,  "len_expired");
    expect_at(p + 25, 4'd0,  "len_stays_off");
    expect_at(p + 40, 4'd0,  "len_stays_off");
    expect_at(p + 60, 4'd0,  "len_stays_off");
    pulse(p + 10, 256);
    pulse(p + 20, 256);
    goto(p + 62);

    // Envelope decay 8 -> 0 and hold
    defaults();
    freq = 11'd0; duty = 2'd2; startVol = 4'd8; period = 3'd1;
    fire(p);
    expect_at(p + 5, 4'd8, "env_initial");
    for (int i = 1; i <= 8; i++) expect_at(p + 10*i + 1, 4'(8 - i), "env_step");
    expect_at(p + 101, 4'd0, "env_floor");
    for (int i = 1; i <= 10; i++) pulse(p + 10*i, 64);
    goto(p + 105);

    // Sweep up: trigger check passes, first sweep overflows on re-check
    defaults();
    freq = 11'd1024; swpPd = 3'd1; shift = 3'd1; duty = 2'd2; startVol = 4'd15;
    fire(p);
    expect_at(p + 5,   4'd15, "sweep_trig_ok");
    expect_at(p + 19,  4'd15, "sweep_before");
    expect_at(p + 21,  4'd0,  "sweep_overflow");
    expect_at(p + 200, 4'd0,  "sweep_stays_off");
    pulse(p + 20, 128);
    goto(p + 205);

    // Trigger-time overflow check boundary: 1365 -> 2047 ok, 1366 -> 2049 overflows
    defaults();
    freq = 11'd1365; shift = 3'd1; duty = 2'd2; startVol = 4'd15;
    fire(p);
    expect_at(p + 3, 4'd15, "trig_chk_2047");
    goto(p + 5);
    freq = 11'd1366;
    fire(p);
    expect_at(p + 3, 4'd0, "trig_chk_2049");
    goto(p + 5);

    // Sweep down: shadow 1792 -> 896 sets the pitch, freq input ignored while sweeping
    defaults();
    freq = 11'd1792; negate = 1'b1; shift = 3'd1; swpPd = 3'd1; duty = 2'd2; startVol = 4'd15;
    fire(p);
    expect_at(p + 1024,  4'd15, "neg_pos0_end");
    expect_at(p + 1025,  4'd0,  "neg_pos1");
    expect_at(p + 5121,  4'd0,  "neg_slower");
    expect_at(p + 19456, 4'd0,  "neg_pos4_end");
    expect_at(p + 19457, 4'd15, "neg_pos5");
    @(negedge clk);
    freq = 11'd0;
    pulse(p + 10, 128);
    goto(p + 19460);

    // DAC off: stays disabled even when the envelope later rises
    defaults();
    freq = 11'd0; duty = 2'd2;
    fire(p);
    expect_at(p + 1,  4'd0, "dac_off_trig");
    expect_at(p + 20, 4'd0, "dac_off_hold");
    expect_at(p + 40, 4'd0, "dac_off_hold");
    goto(p + 10);
    envAdd = 1'b1; period = 3'd1;
    pulse(p + 15, 64);
    pulse(p + 25, 64);
    goto(p + 42);
    fire(q);
    expect_at(q + 5,  4'd0, "env_up_start");
    expect_at(q + 11, 4'd1, "env_up_step");
    pulse(q + 10, 64);
    goto(q + 14);

    // Async reset mid-tone, then trigger held through release
    defaults();
    freq = 11'd0; duty = 2'd2; startVol = 4'd15;
    fire(p);
    expect_at(p + 5,  4'd15, "pre_reset_tone");
    expect_at(p + 10, 4'd0,  "reset_mid_tone");
    expect_at(p + 14, 4'd0,  "post_reset_silent");
    expect_at(p + 30, 4'd0,  "post_reset_silent");
    expect_at(p + 35, 4'd0,  "held_trig_pending");
    expect_at(p + 36, 4'd15, "held_trig_edge");
    expect_at(p + 40, 4'd15, "held_trig_tone");
    goto(p + 9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    goto(p + 12);
    trigger = 1'b0;
    rst_n = 1'b1;
    goto(p + 32);
    rst_n = 1'b0;
    trigger = 1'b1;
    goto(p + 34);
    rst_n = 1'b1;
    goto(p + 43);

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_channel1.md
PULSE_CHANNEL1 -- requirements
Module: pulse_channel1

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  system clock, 4194304 Hz nominal
- rst_n  in  1  asynchronous active-low reset
- clk256  in  1  length tick; single-cycle strobe synchronous to clk
- clk128  in  1  sweep tick; single-cycle strobe
- clk64  in  1  envelope tick; single-cycle strobe
- swpPd  in  3  sweep period
- negate  in  1  sweep direction; 1 = subtract
- shift  in  3  sweep shift
- freq  in  11  frequency register
- lenLoad  in  6  length load
- duty  in  2  duty select
- startVol  in  4  initial envelope volume
- period  in  3  envelope period
- lenEnable  in  1  length counter enable
- trigger  in  1  restart request, rising-edge sensitive
- envAdd  in  1  envelope direction; 1 = increase
- out  out  4  sample to DAC, 0..15
REQ-002 SHALL use one clock domain: clk; strobes are enables, never clocks.

Function
REQ-003 Trigger SHALL fire on a 0->1 transition of trigger sampled at clk; it takes precedence over any strobe in the same cycle.
REQ-004 On trigger: enabled=1; length=64-lenLoad; volume=startVol; envelope timer=period; duty position=0; freq timer=(2048-freq)*4; shadow=freq; sweep timer=swpPd (0 counts as 8); sweepEn=(swpPd!=0 or shift!=0); if shift!=0, run the overflow check immediately.
REQ-005 DAC power: if startVol==0 and envAdd==0, enabled SHALL be forced to 0, including on trigger.
REQ-006 Frequency timer SHALL decrement every clk; on reaching 0 it reloads (2048-curFreq)*4 and advances duty position modulo 8.
REQ-007 curFreq SHALL equal shadow while sweepEn=1, and SHALL track the freq input each clk otherwise.
REQ-008 Duty patterns, position 0..7 left to right: 0=00000001, 1=10000001, 2=10000111, 3=01111110.
REQ-009 Length: on clk256, if lenEnable and length!=0, decrement; reaching 0 SHALL clear enabled; length 0 stays 0.
REQ-010 Envelope: on clk64, if period!=0, decrement envelope timer; at 0 reload period and step volume by +1 (envAdd=1) or -1, saturating at 15 and 0; period==0 freezes volume.
REQ-011 Sweep: on clk128, decrement sweep timer; at 0 reload (0 counts as 8); if sweepEn and swpPd!=0, compute new=shadow±(shadow>>shift) at 12-bit width; if new>2047, clear enabled; else if shift!=0, shadow=new and run the overflow check again.
REQ-012 Overflow check: compute the same value from current shadow; >2047 clears enabled; the result is not stored.
REQ-013 Subtraction SHALL never underflow below 0 (shadow>>shift <= shadow).
REQ-014 out SHALL be registered: volume when enabled=1 and the current duty bit is 1, else 0; updates one clk after the state change.
REQ-015 A disabled channel SHALL stay disabled until the next trigger; the freq timer may keep running.
REQ-016 Implementation SHALL be synthesizable, without latches.

Reset
REQ-017 While rst_n=0, asynchronously: out=0, enabled=0, volume=0, length=0, all timers=0, shadow=0, duty position=0, sweepEn=0, trigger edge register=0.
REQ-018 After release, out SHALL remain 0 until a trigger; trigger held at 1 through release SHALL count as a rising edge.

Verification
REQ-019 Reset asserted mid-tone, any inputs -> out=0 in the same cycle; no output until a new trigger edge.
REQ-020 freq=1792, duty=2, startVol=15, envAdd=0, period=0, lenEnable=0, trigger -> out 15,0,0,0,0,15,15,15 in 1024-clk steps, repeating every 8192 clk.
REQ-021 lenLoad=62, lenEnable=1, startVol=15, trigger -> after the 2nd clk256 strobe, out=0 permanently.
REQ-022 startVol=8, envAdd=0, period=1 -> volume 7,6,...,0 after successive clk64 strobes, then holds 0.
REQ-023 freq=1024, swpPd=1, shift=1, negate=0, trigger -> trigger check passes (1536); 1st clk128 strobe sets shadow=1536, re-check gives 2304 -> out=0.
REQ-024 startVol=0, envAdd=0, trigger -> enabled stays 0, out=0.
